// File: rtl/mem_reader.sv
// Read-side master: walks a (base, length) window of an async-read memory and streams
// the words over valid/ready. Define MEM_READER_WRAP_EN to let the window wrap modulo SIZE.
module mem_reader #(
    parameter int WIDTH = 16,
    parameter int SIZE  = 64,
    parameter int LSIZE = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [LSIZE-1:0] base_addr,
    input  logic [LSIZE:0]   length,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LSIZE-1:0] rd_addr,
    input  logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [LSIZE+1:0] SIZE_W = (LSIZE+2)'(SIZE);
    localparam logic [LSIZE-1:0] LAST   = LSIZE'(SIZE - 1);

    logic [1:0]       state;
    logic [LSIZE-1:0] addr;
    logic [LSIZE:0]   rem;
    logic             legal;
    logic             load;
    logic [LSIZE-1:0] next_addr;

`ifdef MEM_READER_WRAP_EN
    assign legal     = ({1'b0, length} <= SIZE_W);
    assign next_addr = (addr == LAST) ? '0 : addr + 1'b1;
`else
    logic [LSIZE+1:0] end_addr;
    assign end_addr  = {2'b00, base_addr} + {1'b0, length};
    assign legal     = ({1'b0, length} <= SIZE_W) && (end_addr <= SIZE_W);
    // The last legal word may sit at SIZE-1; hold there rather than roll over to 0.
    assign next_addr = (addr == LAST) ? addr : addr + 1'b1;
`endif

    // Refill the output register whenever it is empty or being emptied this cycle.
    assign load    = !out_valid || out_ready;
    assign busy    = (state != IDLE);
    assign rd_addr = addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            addr      <= '0;
            rem       <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (!legal) begin
                            err <= 1'b1;
                        end else if (length == '0) begin
                            done <= 1'b1;
                        end else begin
                            addr  <= base_addr;
                            rem   <= length;
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    if (load) begin
                        out_data  <= rd_data;
                        out_valid <= 1'b1;
                        addr      <= next_addr;
                        rem       <= rem - 1'b1;
                        if (rem == (LSIZE+1)'(1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
